// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the five pipeline registers: load-use, MEM-stage mispredict
// flushes and multi-cycle LSU waits with timeout abort, plus stall/flush perf counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_id_rs1_addr,
    input  logic [4:0]  i_id_rs2_addr,
    input  logic        i_id_rs1_used,
    input  logic        i_id_rs2_used,
    input  logic [4:0]  i_ex_rd_addr,
    input  logic        i_ex_mem_rden,
    input  logic        i_mem_mispred,
    input  logic        i_mem_req,
    input  logic        i_mem_ack,
    input  logic        i_clr_cnt,
    output logic        o_pc_stall,
    output logic        o_ifid_stall,
    output logic        o_ifid_flush,
    output logic        o_idex_stall,
    output logic        o_idex_flush,
    output logic        o_exmem_stall,
    output logic        o_exmem_flush,
    output logic        o_memwb_flush,
    output logic [1:0]  o_state,
    output logic        o_mem_timeout,
    output logic [31:0] o_stall_cnt,
    output logic [15:0] o_flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01
    } state_t;

    localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic memwait;
    logic ldu;
    logic use_run_rules;
    logic flush_apply;
    logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_stall_c, idex_flush_c;
    logic exmem_stall_c, exmem_flush_c, memwb_flush_c;

    assign memwait = i_mem_req & ~i_mem_ack;
    assign ldu     = i_ex_mem_rden & (i_ex_rd_addr != 5'd0)
                   & ((i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr))
                    | (i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr)));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_d     = timeout_q;
        use_run_rules = 1'b0;
        flush_apply   = 1'b0;
        pc_stall_c    = 1'b0;
        ifid_stall_c  = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_stall_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_stall_c = 1'b0;
        exmem_flush_c = 1'b0;
        memwb_flush_c = 1'b0;

        case (state_q)
            RUN: begin
                if (memwait) begin
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    idex_stall_c  = 1'b1;
                    exmem_stall_c = 1'b1;
                    memwb_flush_c = 1'b1;
                    state_d       = MEM_WAIT;
                    wait_cnt_d    = 16'd1;
                end else begin
                    use_run_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!memwait) begin
                    // Access completed (or request withdrawn): behave as RUN this cycle.
                    use_run_rules = 1'b1;
                    state_d       = RUN;
                    wait_cnt_d    = 16'd0;
                end else if (wait_cnt_q >= TIMEOUT_VAL) begin
                    // Drop the stuck access: bubble EX_MEM and MEM_WB, hold the front end.
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    idex_stall_c  = 1'b1;
                    exmem_flush_c = 1'b1;
                    memwb_flush_c = 1'b1;
                    timeout_d     = 1'b1;
                    state_d       = RUN;
                    wait_cnt_d    = 16'd0;
                end else begin
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    idex_stall_c  = 1'b1;
                    exmem_stall_c = 1'b1;
                    memwb_flush_c = 1'b1;
                    wait_cnt_d    = wait_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 16'd0;
            end
        endcase

        if (use_run_rules) begin
            if (i_mem_mispred) begin
                ifid_flush_c  = 1'b1;
                idex_flush_c  = 1'b1;
                exmem_flush_c = 1'b1;
                flush_apply   = 1'b1;
            end else if (ldu) begin
                pc_stall_c   = 1'b1;
                ifid_stall_c = 1'b1;
                idex_flush_c = 1'b1;
            end
        end
    end

    assign o_pc_stall    = pc_stall_c    & ~i_reset;
    assign o_ifid_stall  = ifid_stall_c  & ~i_reset;
    assign o_ifid_flush  = ifid_flush_c  & ~i_reset;
    assign o_idex_stall  = idex_stall_c  & ~i_reset;
    assign o_idex_flush  = idex_flush_c  & ~i_reset;
    assign o_exmem_stall = exmem_stall_c & ~i_reset;
    assign o_exmem_flush = exmem_flush_c & ~i_reset;
    assign o_memwb_flush = memwb_flush_c & ~i_reset;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (i_clr_cnt) begin
            stall_cnt_d = 32'd0;
            flush_cnt_d = 16'd0;
        end else begin
            if (o_pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if (flush_apply && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_d = flush_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= 16'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_state       = state_q;
    assign o_mem_timeout = timeout_q;
    assign o_stall_cnt   = stall_cnt_q;
    assign o_flush_cnt   = flush_cnt_q;

endmodule
